// File: rtl/hlsm_host_ctrl_pkg.sv
// Shared definitions for the HLSM host controller: FSM state encoding,
// default operand width and the watchdog counter sizing helper.
package hlsm_host_ctrl_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    function automatic int wdog_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hlsm_host_ctrl_wdog.sv
// Start-to-Done watchdog: counts cycles since Start and flags expiry once
// TIMEOUT_CYCLES cycles have elapsed; saturates so expiry stays asserted.
module hlsm_wdog
    import hlsm_host_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load counts the Start cycle itself, so expiry lands exactly TIMEOUT_CYCLES after Start
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(1);
        end else if (tick_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/hlsm_host_ctrl.sv
// Initiator for the HLSM Start/Done protocol: takes operand triples, launches the
// datapath, waits for Done under a watchdog and returns the results on a valid/ready port.
module hlsm_host_ctrl
    import hlsm_host_ctrl_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic signed [DATA_W-1:0] in_c,
    output logic                     Start,
    output logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] c,
    input  logic                     Done,
    input  logic signed [DATA_W-1:0] z,
    input  logic signed [DATA_W-1:0] x,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res_z,
    output logic signed [DATA_W-1:0] res_x,
    output logic                     res_err,
    output logic                     spurious,
    output logic [CNT_W-1:0]         n_done,
    output logic [CNT_W-1:0]         n_tmo
);

    state_e state_q, state_d;

    logic                     start_q, start_d;
    logic                     in_ready_q, in_ready_d;
    logic                     res_valid_q, res_valid_d;
    logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic signed [DATA_W-1:0] res_z_q, res_z_d, res_x_q, res_x_d;
    logic                     res_err_q, res_err_d;
    logic                     spurious_q, spurious_d;
    logic [CNT_W-1:0]         n_done_q, n_done_d, n_tmo_q, n_tmo_d;

    logic expire_s;
    logic accept_s;
    logic done_ok_s;
    logic tmo_s;

    hlsm_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .load_i   (state_q == ST_LAUNCH),
        .tick_i   (state_q == ST_WAIT),
        .expire_o (expire_s)
    );

    // Done outranks a simultaneous watchdog expiry
    assign accept_s  = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign done_ok_s = (state_q == ST_WAIT) && Done;
    assign tmo_s     = (state_q == ST_WAIT) && !Done && expire_s;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_ok_s || tmo_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; operands and results hold unless updated
    always_comb begin
        start_d     = accept_s;
        in_ready_d  = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_HOLD);
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        res_z_d     = res_z_q;
        res_x_d     = res_x_q;
        res_err_d   = res_err_q;
        n_done_d    = n_done_q;
        n_tmo_d     = n_tmo_q;
        spurious_d  = spurious_q | (Done && (state_q != ST_WAIT));
        if (accept_s) begin
            a_d = in_a;
            b_d = in_b;
            c_d = in_c;
        end else begin
            a_d = a_q;
            b_d = b_q;
            c_d = c_q;
        end
        if (done_ok_s) begin
            res_z_d   = z;
            res_x_d   = x;
            res_err_d = 1'b0;
            n_done_d  = n_done_q + CNT_W'(1);
        end else if (tmo_s) begin
            res_z_d   = '0;
            res_x_d   = '0;
            res_err_d = 1'b1;
            n_tmo_d   = n_tmo_q + CNT_W'(1);
        end else begin
            res_z_d   = res_z_q;
            res_x_d   = res_x_q;
            res_err_d = res_err_q;
        end
    end

    // Output and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            start_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            res_z_q     <= '0;
            res_x_q     <= '0;
            res_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
            n_done_q    <= '0;
            n_tmo_q     <= '0;
        end else begin
            start_q     <= start_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            res_z_q     <= res_z_d;
            res_x_q     <= res_x_d;
            res_err_q   <= res_err_d;
            spurious_q  <= spurious_d;
            n_done_q    <= n_done_d;
            n_tmo_q     <= n_tmo_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign Start     = start_q;
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign res_valid = res_valid_q;
    assign res_z     = res_z_q;
    assign res_x     = res_x_q;
    assign res_err   = res_err_q;
    assign spurious  = spurious_q;
    assign n_done    = n_done_q;
    assign n_tmo     = n_tmo_q;

endmodule
